// File: rtl/strscan_accel.sv
// String-scan accelerator: fetches a NUL-terminated string over Avalon-MM, reports its length.
// Define STRSCAN_MATCH_COUNT_EN to add the TARGET register and MATCH_CNT byte counter.
module strscan_accel #(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        irq
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic              irq_en_q, done_q, trunc_q;
  logic [31:0]       src_q, ptr_q, word_q, rdata_q;
  logic [1:0]        off_q;
  logic [LEN_W-1:0]  max_q, max_job_q, len_q;
  logic              start, busy;
  logic [LEN_W-1:0]  scan_len;
  logic              scan_term, scan_trunc;
  logic [31:0]       csr_mux;
`ifdef STRSCAN_MATCH_COUNT_EN
  logic [7:0]        target_q, tgt_job_q;
  logic [LEN_W-1:0]  mcnt_q, scan_mcnt;
`endif

  assign start        = avs_write && (avs_address == 3'd0) && avs_writedata[0];
  assign busy         = (state_q == StReq) || (state_q == StWait) || (state_q == StScan);
  assign avm_read     = (state_q == StReq);
  assign avm_address  = ptr_q;
  assign avs_readdata = rdata_q;
  assign irq          = done_q & irq_en_q;

  // Walk bytes offset..3; a NUL ends the string, hitting the job's length limit truncates.
  always_comb begin
    scan_len   = len_q;
    scan_term  = 1'b0;
    scan_trunc = 1'b0;
`ifdef STRSCAN_MATCH_COUNT_EN
    scan_mcnt  = mcnt_q;
`endif
    for (int i = 0; i < 4; i++) begin
      if (!scan_term && (i >= int'(off_q))) begin
        if (word_q[8*i +: 8] == 8'h00) begin
          scan_term = 1'b1;
        end else begin
          scan_len = scan_len + 1'b1;
`ifdef STRSCAN_MATCH_COUNT_EN
          if (word_q[8*i +: 8] == tgt_job_q) scan_mcnt = scan_mcnt + 1'b1;
`endif
          if (scan_len == max_job_q) begin
            scan_term  = 1'b1;
            scan_trunc = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (max_q == '0) ? StDone : StReq;
      StReq:   if (!avm_waitrequest) state_d = StWait;
      StWait:  if (avm_readdatavalid) state_d = StScan;
      StScan:  state_d = scan_term ? StDone : StReq;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    csr_mux = 32'd0;
    case (avs_address)
      3'd0:    csr_mux = {30'd0, irq_en_q, 1'b0};
      3'd1:    csr_mux = {29'd0, trunc_q, done_q, busy};
      3'd2:    csr_mux = src_q;
      3'd3:    csr_mux = 32'(max_q);
      3'd4:    csr_mux = 32'(len_q);
`ifdef STRSCAN_MATCH_COUNT_EN
      3'd5:    csr_mux = {24'd0, target_q};
      3'd6:    csr_mux = 32'(mcnt_q);
`endif
      default: csr_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      trunc_q   <= 1'b0;
      src_q     <= '0;
      ptr_q     <= '0;
      word_q    <= '0;
      rdata_q   <= '0;
      off_q     <= '0;
      max_q     <= '0;
      max_job_q <= '0;
      len_q     <= '0;
`ifdef STRSCAN_MATCH_COUNT_EN
      target_q  <= '0;
      tgt_job_q <= '0;
      mcnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= avs_read ? csr_mux : 32'd0;
      if (avs_write) begin
        case (avs_address)
          3'd0: irq_en_q <= avs_writedata[1];
          3'd1: if (avs_writedata[1]) begin
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
          end
          3'd2: src_q <= avs_writedata;
          3'd3: max_q <= avs_writedata[LEN_W-1:0];
`ifdef STRSCAN_MATCH_COUNT_EN
          3'd5: target_q <= avs_writedata[7:0];
`endif
          default: ;
        endcase
      end
      case (state_q)
        StIdle: if (start) begin
          len_q     <= '0;
          done_q    <= 1'b0;
          trunc_q   <= 1'b0;
          ptr_q     <= {src_q[31:2], 2'b00};
          off_q     <= src_q[1:0];
          max_job_q <= max_q;
`ifdef STRSCAN_MATCH_COUNT_EN
          mcnt_q    <= '0;
          tgt_job_q <= target_q;
`endif
        end
        StWait: if (avm_readdatavalid) word_q <= avm_readdata;
        StScan: begin
          len_q <= scan_len;
`ifdef STRSCAN_MATCH_COUNT_EN
          mcnt_q <= scan_mcnt;
`endif
          if (scan_term) begin
            trunc_q <= scan_trunc;
          end else begin
            ptr_q <= ptr_q + 32'd4;
            off_q <= 2'd0;
          end
        end
        default: ;
      endcase
      // Completion takes priority over a simultaneous STATUS clear.
      if ((state_d == StDone) && (state_q != StDone)) done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_strscan_accel.sv
// Directed self-checking bench for strscan_accel with a byte-array memory fabric model.
module tb_strscan_accel;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata, avm_address, avm_readdata = '0;
  logic        avm_read, avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0, irq;

  strscan_accel #(.LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef STRSCAN_MATCH_COUNT_EN
  localparam int MC_EN = 1;
`else
  localparam int MC_EN = 0;
`endif

  int passed = 0, total = 0;
  logic [7:0]  mem [0:8191];
  int          nreads = 0, req_cycles = 0, stall_left = 0, stall_bad = 0, fab_lat = 0;
  logic [31:0] addr_log [0:7];
  logic [31:0] stall_addr = '0;
  logic        stalling = 1'b0, pend = 1'b0;
  logic [31:0] paddr = '0;
  int          lat = 0;

  // Fabric model: all decisions made on the falling edge, one read outstanding.
  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (!reset_n) begin
      pend = 1'b0;
      avm_waitrequest = 1'b0;
      stalling = 1'b0;
    end else if (pend) begin
      if (lat == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = {mem[paddr[12:0]+3], mem[paddr[12:0]+2],
                        mem[paddr[12:0]+1], mem[paddr[12:0]]};
        pend = 1'b0;
      end else lat--;
    end else if (avm_read) begin
      req_cycles++;
      if (stalling && avm_address !== stall_addr) stall_bad++;
      if (stall_left > 0) begin
        if (!stalling) stall_addr = avm_address;
        stalling = 1'b1;
        stall_left--;
        avm_waitrequest = 1'b1;
      end else begin
        stalling = 1'b0;
        avm_waitrequest = 1'b0;
        if (nreads < 8) addr_log[nreads] = avm_address;
        nreads++;
        pend = 1'b1;
        paddr = avm_address;
        lat = fab_lat;
      end
    end else avm_waitrequest = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_done();
    logic [31:0] s;
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      csr_read(3'd1, s);
      if (s[1]) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic setup_job(input logic [31:0] src, input logic [31:0] mx, input logic [7:0] tg);
    csr_write(3'd2, src);
    csr_write(3'd3, mx);
    csr_write(3'd5, {24'd0, tg});
    nreads = 0; req_cycles = 0; stall_bad = 0;
  endtask

  logic [31:0] r;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'hAA;
    {mem[13'h1000], mem[13'h1001], mem[13'h1002]} = {8'h48, 8'h65, 8'h6c};
    {mem[13'h1003], mem[13'h1004], mem[13'h1005]} = {8'h6c, 8'h6f, 8'h00};
    {mem[13'h1100], mem[13'h1101], mem[13'h1102]} = {8'h78, 8'h78, 8'h61};
    {mem[13'h1103], mem[13'h1104]}                = {8'h62, 8'h00};
    for (int i = 0; i < 6; i++) mem[13'h1200 + i] = 8'h61 + 8'(i);
    mem[13'h1206] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
    chk("rst_avm_addr", avm_address, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      csr_read(3'(i), r);
      chk("rst_csr", r, 32'd0);
    end

    // "Hello" with IRQ enabled
    setup_job(32'h1000, 32'd100, 8'h6c);
    csr_write(3'd0, 32'h3);
    chk("start_avm_read", {31'd0, avm_read}, 32'd1);
    csr_read(3'd1, r);
    chk("start_busy", r, 32'h1);
    wait_done();
    chk("hello_irq", {31'd0, irq}, 32'd1);
    csr_read(3'd4, r); chk("hello_len", r, 32'd5);
    csr_read(3'd6, r); chk("hello_match", r, (MC_EN != 0) ? 32'd2 : 32'd0);
    csr_read(3'd1, r); chk("hello_status", r, 32'h2);
    chk("hello_nreads", 32'(nreads), 32'd2);
    chk("hello_addr0", addr_log[0], 32'h1000);
    chk("hello_addr1", addr_log[1], 32'h1004);
    csr_write(3'd1, 32'h2);
    chk("irq_clear", {31'd0, irq}, 32'd0);
    csr_read(3'd1, r); chk("status_clear", r, 32'h0);
    csr_read(3'd5, r); chk("target_rb", r, (MC_EN != 0) ? 32'h6c : 32'd0);

    // Unaligned start skips leading bytes
    setup_job(32'h1102, 32'd100, 8'h62);
    csr_write(3'd0, 32'h1);
    wait_done();
    csr_read(3'd4, r); chk("unal_len", r, 32'd2);
    csr_read(3'd6, r); chk("unal_match", r, (MC_EN != 0) ? 32'd1 : 32'd0);
    chk("unal_addr0", addr_log[0], 32'h1100);
    chk("unal_nreads", 32'(nreads), 32'd2);

    // Truncation at MAX_LEN
    setup_job(32'h1200, 32'd3, 8'h61);
    csr_write(3'd0, 32'h1);
    wait_done();
    csr_read(3'd4, r); chk("trunc_len", r, 32'd3);
    csr_read(3'd1, r); chk("trunc_status", r, 32'h6);
    chk("trunc_nreads", 32'(nreads), 32'd1);
    chk("trunc_irq_off", {31'd0, irq}, 32'd0);

    // MAX_LEN = 0: no bus traffic
    setup_job(32'h1000, 32'd0, 8'h6c);
    csr_write(3'd0, 32'h1);
    chk("zero_no_read", {31'd0, avm_read}, 32'd0);
    @(negedge clk);
    csr_read(3'd1, r); chk("zero_status", r, 32'h2);
    csr_read(3'd4, r); chk("zero_len", r, 32'd0);
    chk("zero_req_cycles", 32'(req_cycles), 32'd0);

    // Waitrequest stall plus ignored second START and deferred MAX_LEN write
    setup_job(32'h1000, 32'd100, 8'h6c);
    stall_left = 5;
    csr_write(3'd0, 32'h1);
    csr_write(3'd0, 32'h1);
    csr_write(3'd3, 32'd1);
    wait_done();
    repeat (4) @(negedge clk);
    csr_read(3'd4, r); chk("stall_len", r, 32'd5);
    csr_read(3'd6, r); chk("stall_match", r, (MC_EN != 0) ? 32'd2 : 32'd0);
    csr_read(3'd1, r); chk("stall_status", r, 32'h2);
    chk("stall_addr_stable", 32'(stall_bad), 32'd0);
    chk("stall_nreads", 32'(nreads), 32'd2);
    chk("stall_req_cycles", 32'(req_cycles), 32'd7);
    nreads = 0;
    csr_write(3'd0, 32'h1);
    wait_done();
    csr_read(3'd4, r); chk("deferred_max_len", r, 32'd1);
    csr_read(3'd1, r); chk("deferred_status", r, 32'h6);

    // Reset during WAIT
    setup_job(32'h1000, 32'd100, 8'h6c);
    fab_lat = 3;
    csr_write(3'd0, 32'h3);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_avm_read", {31'd0, avm_read}, 32'd0);
    chk("mrst_avm_addr", avm_address, 32'd0);
    chk("mrst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    fab_lat = 0;
    repeat (5) @(negedge clk);
    chk("mrst_no_req", {31'd0, avm_read}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      csr_read(3'(i), r);
      chk("mrst_csr", r, 32'd0);
    end
    setup_job(32'h1000, 32'd100, 8'h6c);
    csr_write(3'd0, 32'h1);
    wait_done();
    csr_read(3'd4, r); chk("post_rst_len", r, 32'd5);
    csr_read(3'd1, r); chk("post_rst_status", r, 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
